// File: rtl/dmem_fact_responder.sv
// rtl/dmem_fact_responder.sv - data-memory responder: RAM, factorial accelerator, GPO register
module dmem_fact_responder #(
    parameter int unsigned RAM_WORDS = 64,
    parameter logic [31:0] FACT_BASE = 32'h0000_0800,
    parameter logic [31:0] GPO_BASE  = 32'h0000_0900,
    parameter int unsigned MAX_N     = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] gpo,
    output logic        fact_busy,
    output logic        fact_irq
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [29:0] FACT_W = FACT_BASE[31:2];
    localparam logic [29:0] GPO_W  = GPO_BASE[31:2];
    localparam logic [3:0]  MAX_N4 = 4'(MAX_N);

    state_t      state, state_next;
    logic [3:0]  n_reg;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] prod, prod_next;
    logic [31:0] result, result_next;
    logic        done, done_next;
    logic        err, err_next;
    logic        irq_next;

    logic [31:0] ram [RAM_WORDS];
    logic [29:0] word;
    logic [5:0]  ram_idx;
    logic        sel_ram, sel_n, sel_go, sel_status, sel_result, sel_gpo;
    logic        go_req;

    // Byte-lane bits are irrelevant for a word-only bus
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign word       = addr[31:2];
    assign ram_idx    = addr[7:2];
    assign sel_ram    = (addr[31:8] == 24'd0);
    assign sel_n      = (word == FACT_W);
    assign sel_go     = (word == FACT_W + 30'd1);
    assign sel_status = (word == FACT_W + 30'd2);
    assign sel_result = (word == FACT_W + 30'd3);
    assign sel_gpo    = (word == GPO_W);
    assign go_req     = we && sel_go && wd[0];

    assign fact_busy = (state == BUSY);

    // RAM store port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            ram[ram_idx] <= wd;
        end
    end

    // Software-writable registers: N operand and general-purpose output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg <= 4'd0;
            gpo   <= 32'd0;
        end else begin
            if (we && sel_n) begin
                n_reg <= wd[3:0];
            end
            if (we && sel_gpo) begin
                gpo <= wd;
            end
        end
    end

    // Accelerator state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            prod     <= 32'd0;
            result   <= 32'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            fact_irq <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            prod     <= prod_next;
            result   <= result_next;
            done     <= done_next;
            err      <= err_next;
            fact_irq <= irq_next;
        end
    end

    // Accelerator next-state: accept GO when not busy, multiply down to 1, then latch result
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        prod_next   = prod;
        result_next = result;
        done_next   = done;
        err_next    = err;
        irq_next    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go_req) begin
                    if (n_reg > MAX_N4) begin
                        err_next    = 1'b1;
                        done_next   = 1'b1;
                        result_next = 32'd0;
                        irq_next    = 1'b1;
                        state_next  = DONE;
                    end else begin
                        cnt_next   = n_reg;
                        prod_next  = 32'd1;
                        done_next  = 1'b0;
                        err_next   = 1'b0;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt > 4'd1) begin
                    prod_next = prod * {28'd0, cnt};
                    cnt_next  = cnt - 4'd1;
                end else begin
                    result_next = prod;
                    done_next   = 1'b1;
                    irq_next    = 1'b1;
                    state_next  = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational load mux; unmapped addresses read as zero
    always_comb begin
        rd = 32'd0;
        if (sel_ram) begin
            rd = ram[ram_idx];
        end else if (sel_n) begin
            rd = {28'd0, n_reg};
        end else if (sel_go) begin
            rd = {31'd0, fact_busy};
        end else if (sel_status) begin
            rd = {30'd0, err, done};
        end else if (sel_result) begin
            rd = result;
        end else if (sel_gpo) begin
            rd = gpo;
        end
    end

endmodule

// File: tb/tb_dmem_fact_responder.sv
// tb/tb_dmem_fact_responder.sv - bench for dmem_fact_responder
module tb_dmem_fact_responder;

    localparam logic [31:0] A_N      = 32'h0000_0800;
    localparam logic [31:0] A_GO     = 32'h0000_0804;
    localparam logic [31:0] A_STATUS = 32'h0000_0808;
    localparam logic [31:0] A_RESULT = 32'h0000_080C;
    localparam logic [31:0] A_GPO    = 32'h0000_0900;
    localparam logic [31:0] A_UNMAP  = 32'h0000_0A00;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] gpo;
    logic        fact_busy;
    logic        fact_irq;

    dmem_fact_responder dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd),
        .gpo       (gpo),
        .fact_busy (fact_busy),
        .fact_irq  (fact_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    logic [31:0] exp_q [$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act);
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %h, no expected value queued", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h, want %h", name, act, e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
        expect_val(e);
        check(name, act);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        addr = a;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
        we = 1'b0;
        addr = a;
        expect_val(e);
        #1;
        check(name, rd);
    endtask

    task automatic run_fact(input string tag, input logic [31:0] n, input logic [31:0] exp_res,
                            input logic [31:0] exp_status, input int exp_busy, input int exp_done_at);
        int busy_cnt;
        int irq_cnt;
        int done_at;
        wr(A_N, n);
        wr(A_GO, 32'd1);
        addr = A_STATUS;
        busy_cnt = 0;
        irq_cnt = 0;
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (fact_busy) busy_cnt++;
            if (fact_irq) irq_cnt++;
            if (done_at < 0 && rd[0]) done_at = i;
            @(posedge clk);
            #1;
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        chk({tag, "_irq_pulses"}, 32'(irq_cnt), 32'd1);
        chk({tag, "_done_latency"}, 32'(done_at), 32'(exp_done_at));
        rd_chk({tag, "_status"}, A_STATUS, exp_status);
        rd_chk({tag, "_result"}, A_RESULT, exp_res);
        rd_chk({tag, "_go_read"}, A_GO, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"rst_n",          1'b0, A_N,        32'd0,         1'b1, 32'd0};
        vecs[1]  = '{"rst_go",         1'b0, A_GO,       32'd0,         1'b1, 32'd0};
        vecs[2]  = '{"rst_status",     1'b0, A_STATUS,   32'd0,         1'b1, 32'd0};
        vecs[3]  = '{"rst_result",     1'b0, A_RESULT,   32'd0,         1'b1, 32'd0};
        vecs[4]  = '{"rst_gpo",        1'b0, A_GPO,      32'd0,         1'b1, 32'd0};
        vecs[5]  = '{"ram_init_wr",    1'b1, 32'h10,     32'h1111_1111, 1'b0, 32'd0};
        vecs[6]  = '{"ram_wr_old",     1'b1, 32'h10,     32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
        vecs[7]  = '{"ram_rd",         1'b0, 32'h10,     32'd0,         1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{"ram_rd_bytealias",1'b0, 32'h13,    32'd0,         1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{"unmap_rd",       1'b0, A_UNMAP,    32'd0,         1'b1, 32'd0};
        vecs[10] = '{"unmap_wr",       1'b1, A_UNMAP,    32'h5,         1'b1, 32'd0};
        vecs[11] = '{"unmap_rd2",      1'b0, A_UNMAP,    32'd0,         1'b1, 32'd0};
        vecs[12] = '{"gpo_wr_old",     1'b1, A_GPO,      32'hA5,        1'b1, 32'd0};
        vecs[13] = '{"gpo_rd",         1'b0, A_GPO,      32'd0,         1'b1, 32'hA5};
        vecs[14] = '{"status_ro_wr",   1'b1, A_STATUS,   32'hFFFF_FFFF, 1'b1, 32'd0};
        vecs[15] = '{"status_ro_rd",   1'b0, A_STATUS,   32'd0,         1'b1, 32'd0};
        vecs[16] = '{"n_wr_mask",      1'b1, A_N,        32'hFFFF_FFF7, 1'b1, 32'd0};
        vecs[17] = '{"n_rd",           1'b0, A_N,        32'd0,         1'b1, 32'd7};
        vecs[18] = '{"go_zero_wr",     1'b1, A_GO,       32'd0,         1'b1, 32'd0};

        rst = 1'b0;
        we = 1'b0;
        addr = 32'd0;
        wd = 32'd0;
        repeat (2) @(posedge clk);
        chk("rst_busy", {31'd0, fact_busy}, 32'd0);
        chk("rst_irq", {31'd0, fact_irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            we = vecs[i].we;
            addr = vecs[i].addr;
            wd = vecs[i].wd;
            if (vecs[i].chk) expect_val(vecs[i].exp_rd);
            #1;
            if (vecs[i].chk) check(vecs[i].name, rd);
            @(posedge clk);
            #1;
            we = 1'b0;
        end
        chk("gpo_port", gpo, 32'hA5);
        rd_chk("go_zero_status", A_STATUS, 32'd0);
        chk("go_zero_busy", {31'd0, fact_busy}, 32'd0);

        run_fact("n5", 32'd5, 32'd120, 32'd1, 5, 5);
        run_fact("n12", 32'd12, 32'h1C8C_FC00, 32'd1, 12, 12);
        run_fact("n0", 32'd0, 32'd1, 32'd1, 1, 1);
        run_fact("n13", 32'd13, 32'd0, 32'd3, 0, 0);

        // GO and N writes while busy must not disturb the running computation
        wr(A_N, 32'd6);
        wr(A_GO, 32'd1);
        wr(A_N, 32'd3);
        wr(A_GO, 32'd1);
        addr = A_STATUS;
        begin
            int waited;
            waited = 0;
            #1;
            while (!(rd[0] && !fact_busy) && waited < 40) begin
                @(posedge clk);
                #1;
                waited++;
            end
            chk("restart_timeout", 32'(waited < 40), 32'd1);
        end
        rd_chk("restart_result", A_RESULT, 32'd720);
        rd_chk("restart_n", A_N, 32'd3);
        rd_chk("restart_status", A_STATUS, 32'd1);

        // Asynchronous reset in the middle of a computation
        wr(A_N, 32'd10);
        wr(A_GO, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, fact_busy}, 32'd0);
        chk("midrst_irq", {31'd0, fact_irq}, 32'd0);
        chk("midrst_gpo", gpo, 32'd0);
        rd_chk("midrst_status", A_STATUS, 32'd0);
        rd_chk("midrst_result", A_RESULT, 32'd0);
        rd_chk("midrst_n", A_N, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_fact("n4", 32'd4, 32'd24, 32'd1, 4, 4);

        wr(A_GPO, 32'h0000_00A5);
        chk("gpo_port2", gpo, 32'hA5);
        rd_chk("gpo_rd2", A_GPO, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_fact_responder.md
Name: dmem_fact_responder

Overview:
- Responder end of the core's data-memory bus; answers every store and load the single-cycle MIPS core issues.
- Decodes the word-aligned address and serves three regions:
  - a 64-word data RAM;
  - a memory-mapped iterative factorial accelerator with a start/status handshake;
  - a 32-bit general-purpose output register.
- Loads are combinational, so the single-cycle core can use them in the same cycle. Stores commit on the rising clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; index is addr[7:2].
- FACT_BASE, 32'h0000_0800, base of the 4-register factorial block.
- GPO_BASE, 32'h0000_0900, address of the GPO register.
- MAX_N, 12, largest n whose factorial fits in 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  store strobe from the core
- addr  in  32  byte address from the core ALU; addr[1:0] ignored
- wd  in  32  store data
- rd  out  32  load data, combinational
- gpo  out  32  GPO register contents
- fact_busy  out  1  high while the accelerator is computing
- fact_irq  out  1  one-cycle pulse on completion

Behaviour:
- Address map, matching on addr[31:2]:
  - RAM when addr[31:8]==0. Write and read are both allowed.
  - FACT_BASE+0, N. Writes store wd[3:0]. Reads return {28'b0,N}.
  - FACT_BASE+4, GO. Writing wd[0]=1 requests a start. Reads return {31'b0,fact_busy}.
  - FACT_BASE+8, STATUS, read-only. Reads return {30'b0,err,done}.
  - FACT_BASE+C, RESULT, read-only.
  - GPO_BASE, GPO. Writes store wd. Reads return gpo.
  - Unmapped addresses, or writes to read-only registers, are ignored. Unmapped reads return 0.
- Reset (rst low, any time, including mid-computation), values asserted immediately:
  - N=0, done=0, err=0, RESULT=0, gpo=0;
  - fact_busy=0, fact_irq=0, FSM=IDLE.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, DONE. DONE differs from IDLE only in that done=1 is held.
- IDLE/DONE, on the edge where a GO write has wd[0]=1:
  - If N>MAX_N: err=1, done=1, RESULT=0, fact_irq pulses on the next cycle, go to DONE. Total 1 cycle.
  - Otherwise: cnt=N, prod=1, done=0, err=0, go to BUSY.
- BUSY, each edge:
  - If cnt>1: prod=prod*cnt (low 32 bits), cnt=cnt-1.
  - Else: RESULT=prod, done=1, go to DONE, fact_irq=1 for exactly one cycle.
  - done is visible max(N,1) edges after the GO-write edge.
- A GO write while BUSY is ignored, with no restart.
- Writing N while BUSY updates the N register only; the running computation uses the latched cnt.
- RESULT is stable from the done edge until the next accepted GO. A STATUS read has no side effect.
- A GO write with wd[0]=0 does nothing.
- Store and load to the same address in the same cycle: rd shows the old value, and the new value is visible after the edge.

Test Plan:
- RAM: store 32'hDEADBEEF at 0x0010, then load 0x0010 gives 32'hDEADBEEF. Load 0x0014 (never written) is not checked. Load 0x0A00 gives 0.
- N=5, GO=1: fact_busy=1 for 5 cycles, then fact_irq pulses once. STATUS=1, RESULT=120. GO reads 0.
- N=12, GO=1: after 12 cycles RESULT=32'h1C8C_FC00 (479001600). N=0 then GO gives RESULT=1, done after 1 cycle.
- N=13, GO=1: after 1 edge STATUS=32'h3 (err, done), RESULT=0, fact_busy never asserts.
- N=6, GO, then on cycle 2 write N=3 and GO: completes with RESULT=720. N reads 3.
- N=10, GO, rst low on cycle 4: all outputs 0 and STATE=IDLE. After release, N=4, GO gives RESULT=24. GPO: write 32'h0000_00A5 to 0x0900, gpo=32'hA5, and rd at 0x0900 returns 32'hA5.
